// File: rtl/dft_top_stream.sv
// 1024-point radix-2 DIT FFT with one butterfly per cycle and a register-array working memory.
// Output is DFT/N in natural bin order, two complex samples per cycle in and out.
module dft_top_stream #(
  parameter int LOG2N = 10,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          next,
  input  logic [DW-1:0] X0,
  input  logic [DW-1:0] X1,
  input  logic [DW-1:0] X2,
  input  logic [DW-1:0] X3,
  output logic          next_out,
  output logic [DW-1:0] Y0,
  output logic [DW-1:0] Y1,
  output logic [DW-1:0] Y2,
  output logic [DW-1:0] Y3,
  output logic [1:0]    dbg_state
);

  localparam int  N       = 1 << LOG2N;
  localparam int  HN      = N / 2;
  localparam int  HW      = LOG2N - 1;
  localparam int  SW      = $clog2(LOG2N);
  localparam int  LATENCY = HN + LOG2N * HN + 1;
  localparam real PI      = 3.14159265358979323846;

  localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG2N - 1);
  localparam logic [LOG2N-1:0] OUT_END    = LOG2N'(HN);

  if (LATENCY > 6000) begin : g_latency_check
    $error("dft_top_stream: LATENCY exceeds 6000 cycles");
  end

  // Stream protocol: no backpressure. 'next' is a one-cycle strobe accepted only in IDLE;
  // samples t=0..N/2-1 follow on consecutive cycles. 'next_out' is a one-cycle strobe and
  // bins follow on the next N/2 consecutive cycles.
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMP, S_OUT} state_t;

  state_t state, state_nx;

  logic [HW-1:0]    cnt;
  logic [SW-1:0]    stage;
  logic [LOG2N-1:0] ocnt;

  logic load_last, comp_last, out_last;

  logic signed [DW-1:0] mem_re [N];
  logic signed [DW-1:0] mem_im [N];
  logic signed [DW-1:0] tw_re  [HN];
  logic signed [DW-1:0] tw_im  [HN];

  function automatic int q15(input real v);
    int q;
    q = $rtoi($floor(v * real'(1 << (DW - 1)) + 0.5));
    if (q > (1 << (DW - 1)) - 1) q = (1 << (DW - 1)) - 1;
    return q;
  endfunction

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  for (genvar k = 0; k < HN; k++) begin : g_tw
    localparam real ANG = 2.0 * PI * real'(k) / real'(N);
    localparam int  WR  = q15($cos(ANG));
    localparam int  WI  = q15(-$sin(ANG));
    assign tw_re[k] = DW'(WR);
    assign tw_im[k] = DW'(WI);
  end

  assign load_last = (state == S_LOAD) && (&cnt);
  assign comp_last = (state == S_COMP) && (&cnt) && (stage == LAST_STAGE);
  assign out_last  = (state == S_OUT) && (ocnt == OUT_END);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (next)      state_nx = S_LOAD;
      S_LOAD:  if (load_last) state_nx = S_COMP;
      S_COMP:  if (comp_last) state_nx = S_OUT;
      S_OUT:   if (out_last)  state_nx = S_IDLE;
      default:                state_nx = S_IDLE;
    endcase
  end

  // Butterfly j of stage s pairs a = ((j>>s)<<(s+1)) | (j & (2^s-1)) with b = a + 2^s.
  logic [HW-1:0]        pos_mask, pos, tw_k;
  logic [LOG2N-1:0]     a_addr, b_addr;
  logic signed [DW-1:0] a_re, a_im, b_re, b_im, w_re, w_im, t_re, t_im;
  logic signed [DW-1:0] na_re, na_im, nb_re, nb_im;
  logic signed [2*DW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [2*DW:0]   s_re, s_im;
  logic signed [DW:0]     sa_re, sa_im, sb_re, sb_im;

  always_comb begin
    pos_mask = HW'((1 << stage) - 1);
    pos      = cnt & pos_mask;
    a_addr   = {cnt & ~pos_mask, 1'b0} | {1'b0, pos};
    b_addr   = a_addr | (LOG2N'(1) << stage);
    tw_k     = pos << (SW'(HW) - stage);

    a_re = mem_re[a_addr];
    a_im = mem_im[a_addr];
    b_re = mem_re[b_addr];
    b_im = mem_im[b_addr];
    w_re = tw_re[tw_k];
    w_im = tw_im[tw_k];

    p_rr = (2*DW)'(b_re) * (2*DW)'(w_re);
    p_ii = (2*DW)'(b_im) * (2*DW)'(w_im);
    p_ri = (2*DW)'(b_re) * (2*DW)'(w_im);
    p_ir = (2*DW)'(b_im) * (2*DW)'(w_re);
    s_re = (2*DW+1)'(p_rr) - (2*DW+1)'(p_ii);
    s_im = (2*DW+1)'(p_ri) + (2*DW+1)'(p_ir);

    // W = 1 cannot be represented in Q1.15, so k = 0 passes b through unscaled.
    if (tw_k == '0) begin
      t_re = b_re;
      t_im = b_im;
    end else begin
      t_re = DW'(s_re >>> (DW - 1));
      t_im = DW'(s_im >>> (DW - 1));
    end

    sa_re = (DW+1)'(a_re) + (DW+1)'(t_re);
    sa_im = (DW+1)'(a_im) + (DW+1)'(t_im);
    sb_re = (DW+1)'(a_re) - (DW+1)'(t_re);
    sb_im = (DW+1)'(a_im) - (DW+1)'(t_im);
    na_re = DW'(sa_re >>> 1);
    na_im = DW'(sa_im >>> 1);
    nb_re = DW'(sb_re >>> 1);
    nb_im = DW'(sb_im >>> 1);
  end

  always_ff @(posedge clk) begin
    if (reset && state == S_LOAD) begin
      mem_re[bitrev({cnt, 1'b0})] <= X0;
      mem_im[bitrev({cnt, 1'b0})] <= X1;
      mem_re[bitrev({cnt, 1'b1})] <= X2;
      mem_im[bitrev({cnt, 1'b1})] <= X3;
    end else if (reset && state == S_COMP) begin
      mem_re[a_addr] <= na_re;
      mem_im[a_addr] <= na_im;
      mem_re[b_addr] <= nb_re;
      mem_im[b_addr] <= nb_im;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      stage    <= '0;
      ocnt     <= '0;
      next_out <= 1'b0;
      Y0       <= '0;
      Y1       <= '0;
      Y2       <= '0;
      Y3       <= '0;
    end else begin
      next_out <= comp_last;
      case (state)
        S_LOAD: cnt <= cnt + HW'(1);
        S_COMP: begin
          cnt <= cnt + HW'(1);
          if (&cnt) stage <= (stage == LAST_STAGE) ? '0 : stage + SW'(1);
        end
        S_OUT:  ocnt <= out_last ? '0 : ocnt + LOG2N'(1);
        default: begin
          cnt   <= '0;
          stage <= '0;
          ocnt  <= '0;
        end
      endcase
      // The first OUT cycle carries the strobe; bins follow from the next cycle.
      if (state == S_OUT && !out_last) begin
        Y0 <= mem_re[{ocnt[HW-1:0], 1'b0}];
        Y1 <= mem_im[{ocnt[HW-1:0], 1'b0}];
        Y2 <= mem_re[{ocnt[HW-1:0], 1'b1}];
        Y3 <= mem_im[{ocnt[HW-1:0], 1'b1}];
      end else begin
        Y0 <= '0;
        Y1 <= '0;
        Y2 <= '0;
        Y3 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dft_top_stream.sv
// Bench for dft_top_stream: drives whole frames, queues the expected bins, and checks
// them as the output frame streams out, plus strobe/latency/reset behaviour.
`timescale 1ns/1ps
module tb_dft_top_stream;

  localparam int  LOG2N   = 10;
  localparam int  DW      = 16;
  localparam int  N       = 1 << LOG2N;
  localparam int  HN      = N / 2;
  localparam int  LATENCY = HN + LOG2N * HN + 1;
  localparam real PI      = 3.14159265358979323846;
  localparam int  TOL     = 16;
  localparam int  M_DC = 0, M_IMP = 1, M_NYQ = 2, M_TONE = 3;

  logic          clk = 1'b0;
  logic          reset, next;
  logic [DW-1:0] X0, X1, X2, X3;
  logic          next_out;
  logic [DW-1:0] Y0, Y1, Y2, Y3;
  logic [1:0]    dbg_state;

  dft_top_stream #(.LOG2N(LOG2N), .DW(DW)) dut (
    .clk(clk), .reset(reset), .next(next),
    .X0(X0), .X1(X1), .X2(X2), .X3(X3),
    .next_out(next_out),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter / strobe counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nout_cnt = 0;
  always @(negedge clk) if (next_out === 1'b1) nout_cnt++;

  // scoreboard
  logic [31:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;
  int t_next  = 0;
  int cur_mode = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] stim(input int mode, input int n);
    int re, im;
    real a;
    re = 0;
    im = 0;
    case (mode)
      M_DC:  re = 10;
      M_IMP: re = (n == 0) ? 1024 : 0;
      M_NYQ: re = (n % 2 == 0) ? 10 : -10;
      default: begin
        a  = 2.0 * PI * real'(n) / real'(N);
        re = $rtoi($floor(16384.0 * $cos(a) + 0.5));
        im = $rtoi($floor(16384.0 * $sin(a) + 0.5));
      end
    endcase
    return {re[15:0], im[15:0]};
  endfunction

  function automatic logic [31:0] exp_bin(input int mode, input int k);
    int re;
    re = 0;
    case (mode)
      M_DC:  re = (k == 0) ? 10 : 0;
      M_IMP: re = 1;
      M_NYQ: re = (k == HN) ? 10 : 0;
      default: re = (k == 1) ? 16384 : 0;
    endcase
    return {re[15:0], 16'h0000};
  endfunction

  // driver
  task automatic send_frame(input int mode, input bit pulse_mid);
    logic [31:0] s0, s1;
    for (int k = 0; k < N; k++) exp_q.push_back(exp_bin(mode, k));
    cur_mode = mode;
    @(posedge clk);
    #1 next = 1'b1;
    @(posedge clk);
    t_next = cyc;
    #1 next = 1'b0;
    for (int t = 0; t < HN; t++) begin
      s0 = stim(mode, 2 * t);
      s1 = stim(mode, 2 * t + 1);
      {X0, X1} = s0;
      {X2, X3} = s1;
      next = pulse_mid && (t == 100);
      @(posedge clk);
      #1;
    end
    {X0, X1, X2, X3} = '0;
    next = 1'b0;
  endtask

  task automatic cmp_bin(input string name, input int k, input logic [31:0] obs);
    logic [31:0] e, used;
    int dr, di;
    bit ok;
    e    = exp_q.pop_front();
    used = obs;
    if (cur_mode == M_TONE) begin
      dr = int'($signed(obs[31:16])) - int'($signed(e[31:16]));
      di = int'($signed(obs[15:0])) - int'($signed(e[15:0]));
      if (k == 1) ok = (dr <= TOL) && (dr >= -TOL) && (di <= TOL) && (di >= -TOL);
      else        ok = (dr * dr + di * di) <= TOL * TOL;
      if (ok) used = e;
    end
    check_eq($sformatf("%s_bin%0d", name, k), used, e);
  endtask

  task automatic collect_frame(input string name);
    bit found;
    found = 1'b0;
    check_eq({name, "_q_size"}, exp_q.size(), N);
    for (int i = 0; i < LATENCY + 200 && !found; i++) begin
      @(negedge clk);
      if (next_out === 1'b1) found = 1'b1;
    end
    if (!found) begin
      check_eq({name, "_next_out_seen"}, 32'd0, 32'd1);
      exp_q.delete();
      return;
    end
    check_eq({name, "_latency"}, cyc - t_next, LATENCY);
    for (int t = 0; t < HN; t++) begin
      @(negedge clk);
      if (t == 0) check_eq({name, "_strobe_width"}, next_out, 0);
      cmp_bin(name, 2 * t, {Y0, Y1});
      cmp_bin(name, 2 * t + 1, {Y2, Y3});
    end
    @(negedge clk);
    check_eq({name, "_y01_after"}, {Y0, Y1}, 0);
    check_eq({name, "_y23_after"}, {Y2, Y3}, 0);
    check_eq({name, "_state_after"}, dbg_state, 0);
  endtask

  task automatic run_frame(input int mode, input string name);
    send_frame(mode, 1'b0);
    collect_frame(name);
  endtask

  initial begin
    int prev;
    reset = 1'b0;
    next  = 1'b0;
    {X0, X1, X2, X3} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_y01", {Y0, Y1}, 0);
    check_eq("rst_y23", {Y2, Y3}, 0);
    check_eq("rst_next_out", next_out, 0);
    check_eq("rst_state", dbg_state, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (20) @(posedge clk);
    check_eq("idle_no_strobe", nout_cnt, 0);

    run_frame(M_DC,   "dc");
    run_frame(M_IMP,  "imp");
    run_frame(M_NYQ,  "nyq");
    run_frame(M_TONE, "tone");

    // next pulsed during LOAD and COMP must not start another frame
    prev = nout_cnt;
    send_frame(M_IMP, 1'b1);
    repeat (3) begin
      repeat (500) @(posedge clk);
      #1 next = 1'b1;
      @(posedge clk);
      #1 next = 1'b0;
    end
    collect_frame("ign");
    repeat (LATENCY + 100) @(posedge clk);
    check_eq("ign_single_strobe", nout_cnt - prev, 1);

    // reset in the middle of COMP aborts the frame
    prev = nout_cnt;
    send_frame(M_DC, 1'b0);
    repeat (1000) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_eq("abort_state", dbg_state, 0);
    check_eq("abort_y01", {Y0, Y1}, 0);
    repeat (LATENCY + 100) @(posedge clk);
    check_eq("abort_no_strobe", nout_cnt - prev, 0);

    run_frame(M_NYQ, "fresh");
    @(posedge clk);
    check_eq("strobe_total", nout_cnt, 6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
